// File: rtl/vga_entity_renderer.sv
// VGA timing generator and entity-to-colour renderer for the snake game.
// Counters drive x_out/y_out; colour and syncs come out ENT_LATENCY+1 cycles later, aligned.
module vga_entity_renderer #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int ENT_LATENCY = 1
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic [1:0]  entity,
  input  logic [2:0]  game_state,
  input  logic        game_over,
  output logic [9:0]  x_out,
  output logic [9:0]  y_out,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb,
  output logic        frame_start
);

  localparam logic [1:0] ENT_NOTHING    = 2'd0;
  localparam logic [1:0] ENT_SNAKE_HEAD = 2'd1;
  localparam logic [1:0] ENT_SNAKE_TAIL = 2'd2;
  localparam logic [1:0] ENT_APPLE      = 2'd3;
  localparam logic [2:0] STATE_INGAME   = 3'd1;
  localparam logic [2:0] STATE_TEST     = 3'd3;

  localparam int         LAST      = ENT_LATENCY - 1;
  localparam logic [9:0] H_VIS     = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS     = 10'(V_ACTIVE);
  localparam logic [9:0] H_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS_FIRST  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0]  hCnt_q, hCnt_d;
  logic [9:0]  vCnt_q, vCnt_d;
  logic [5:0]  frameCnt_q, frameCnt_d;
  logic        actPipe_q [ENT_LATENCY];
  logic        hsPipe_q  [ENT_LATENCY];
  logic        vsPipe_q  [ENT_LATENCY];
  logic        goPipe_q  [ENT_LATENCY];
  logic [11:0] rgb_q, rgb_d;
  logic        hsync_q, vsync_q;
  logic        active0, hsRaw0, vsRaw0;

  assign active0     = (hCnt_q < H_VIS) && (vCnt_q < V_VIS);
  assign hsRaw0      = !((hCnt_q >= HS_FIRST) && (hCnt_q <= HS_LAST));
  assign vsRaw0      = !((vCnt_q >= VS_FIRST) && (vCnt_q <= VS_LAST));
  assign x_out       = active0 ? hCnt_q : 10'd0;
  assign y_out       = active0 ? vCnt_q : 10'd0;
  assign frame_start = reset_n && (hCnt_q == 10'd0) && (vCnt_q == 10'd0);
  assign rgb         = rgb_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;

  always_comb begin
    hCnt_d     = hCnt_q + 10'd1;
    vCnt_d     = vCnt_q;
    frameCnt_d = frameCnt_q + {5'd0, frame_start};
    if (hCnt_q == H_LAST) begin
      hCnt_d = 10'd0;
      vCnt_d = (vCnt_q == V_LAST) ? 10'd0 : vCnt_q + 10'd1;
    end
  end

  // Entity arrives aligned with the last pipeline stage, so colour is decided there.
  always_comb begin
    rgb_d = 12'h000;
    if (actPipe_q[LAST]) begin
      if ((game_state == STATE_INGAME) || (game_state == STATE_TEST)) begin
        case (entity)
          ENT_SNAKE_HEAD: rgb_d = 12'h0F0;
          ENT_SNAKE_TAIL: rgb_d = 12'h080;
          ENT_APPLE:      rgb_d = 12'hF00;
          default:        rgb_d = 12'h000;
        endcase
        if ((game_state == STATE_INGAME) && goPipe_q[LAST] && frameCnt_q[5] &&
            (entity == ENT_NOTHING)) begin
          rgb_d = 12'h400;
        end
      end else begin
        rgb_d = 12'h111;
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      hCnt_q     <= 10'd0;
      vCnt_q     <= 10'd0;
      frameCnt_q <= 6'd0;
      for (int i = 0; i < ENT_LATENCY; i++) begin
        actPipe_q[i] <= 1'b0;
        hsPipe_q[i]  <= 1'b1;
        vsPipe_q[i]  <= 1'b1;
        goPipe_q[i]  <= 1'b0;
      end
      rgb_q   <= 12'h000;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      hCnt_q       <= hCnt_d;
      vCnt_q       <= vCnt_d;
      frameCnt_q   <= frameCnt_d;
      actPipe_q[0] <= active0;
      hsPipe_q[0]  <= hsRaw0;
      vsPipe_q[0]  <= vsRaw0;
      goPipe_q[0]  <= game_over;
      for (int i = 1; i < ENT_LATENCY; i++) begin
        actPipe_q[i] <= actPipe_q[i-1];
        hsPipe_q[i]  <= hsPipe_q[i-1];
        vsPipe_q[i]  <= vsPipe_q[i-1];
        goPipe_q[i]  <= goPipe_q[i-1];
      end
      rgb_q   <= rgb_d;
      hsync_q <= hsPipe_q[LAST];
      vsync_q <= vsPipe_q[LAST];
    end
  end

endmodule

// File: tb/tb_vga_entity_renderer.sv
// Scoreboard bench for vga_entity_renderer on a shrunken 16x11 timing grid.
// The driver pushes expected per-cycle outputs; a negedge monitor pops and compares.
module tb_vga_entity_renderer;

  localparam int HA = 8, HFP = 2, HS = 3, HBP = 3;
  localparam int VA = 6, VFP = 1, VS = 2, VBP = 2;
  localparam int HT = 16, VT = 11, FRAME = 176;

  localparam logic [1:0] ENT_NOTHING = 2'd0, ENT_HEAD = 2'd1, ENT_TAIL = 2'd2, ENT_APPLE = 2'd3;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_INGAME = 3'd1, ST_OVER = 3'd2, ST_TEST = 3'd3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  entity = 2'd0;
  logic [2:0]  gameState = ST_IDLE;
  logic        gameOver = 1'b0;
  logic [9:0]  xOut, yOut;
  logic        hsync, vsync, frameStart;
  logic [11:0] rgb;

  vga_entity_renderer #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .ENT_LATENCY(1)
  ) dut (
    .vga_clk(clk), .reset_n(reset_n), .entity(entity), .game_state(gameState),
    .game_over(gameOver), .x_out(xOut), .y_out(yOut), .hsync(hsync), .vsync(vsync),
    .rgb(rgb), .frame_start(frameStart)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        fs;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } expT;

  typedef struct {
    int   h;
    int   v;
    logic go;
  } histT;

  expT  expQ[$];
  int   vecCount = 0;
  int   missCount = 0;
  int   mh = 0, mv = 0, fcnt = 0, mode = 0;
  logic rstE1 = 1'b0, rstE2 = 1'b0;
  histT hist1 = '{0, 0, 1'b0};
  histT hist2 = '{0, 0, 1'b0};

  // Game-logic stand-in: entity for a given (already gated) coordinate.
  function automatic logic [1:0] entityFor(input int x, input int y, input int m);
    case (m)
      0:       return (x == 3 && y == 2) ? ENT_APPLE : ENT_NOTHING;
      1:       return ENT_HEAD;
      3:       return 2'(x % 4);
      default: return ENT_NOTHING;
    endcase
  endfunction

  function automatic logic [11:0] colourOf(input int h, input int v, input logic go,
                                           input logic [1:0] ent, input logic [2:0] gs,
                                           input int fc);
    if (!(h < HA && v < VA)) return 12'h000;
    if (gs != ST_INGAME && gs != ST_TEST) return 12'h111;
    if (gs == ST_INGAME && go && fc >= 32 && ent == ENT_NOTHING) return 12'h400;
    case (ent)
      ENT_HEAD:  return 12'h0F0;
      ENT_TAIL:  return 12'h080;
      ENT_APPLE: return 12'hF00;
      default:   return 12'h000;
    endcase
  endfunction

  // Runs n cycles with fixed settings, tracking the reference timing and queueing expectations.
  task automatic applyStimulus(input int n, input logic rstnVal, input int modeVal,
                               input logic goVal, input logic [2:0] gsVal);
    expT        e;
    logic [1:0] entE;
    logic [2:0] gsE;
    bit         act;
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      rstE2 = rstE1;
      rstE1 = reset_n;
      entE  = entity;
      gsE   = gameState;
      if (!rstE1 || !rstE2) begin
        e.rgb = 12'h000;
        e.hs  = 1'b1;
        e.vs  = 1'b1;
      end else begin
        e.rgb = colourOf(hist2.h, hist2.v, hist2.go, entE, gsE, fcnt);
        e.hs  = !(hist2.h >= HA + HFP && hist2.h < HA + HFP + HS);
        e.vs  = !(hist2.v >= VA + VFP && hist2.v < VA + VFP + VS);
      end
      if (!rstE1) begin
        mh = 0; mv = 0; fcnt = 0;
      end else begin
        if (mh == 0 && mv == 0) fcnt = (fcnt + 1) % 64;
        mh++;
        if (mh == HT) begin
          mh = 0;
          mv++;
          if (mv == VT) mv = 0;
        end
      end
      reset_n   = rstnVal;
      mode      = modeVal;
      gameOver  = goVal;
      gameState = gsVal;
      act = (hist1.h < HA && hist1.v < VA);
      entity = entityFor(act ? hist1.h : 0, act ? hist1.v : 0, mode);
      act  = (mh < HA && mv < VA);
      e.x  = act ? 10'(mh) : 10'd0;
      e.y  = act ? 10'(mv) : 10'd0;
      e.fs = reset_n && mh == 0 && mv == 0;
      expQ.push_back(e);
      hist2 = hist1;
      hist1 = '{mh, mv, gameOver};
    end
  endtask

  task automatic checkOutput(input expT e);
    vecCount++;
    if (xOut !== e.x || yOut !== e.y || frameStart !== e.fs || hsync !== e.hs ||
        vsync !== e.vs || rgb !== e.rgb) begin
      missCount++;
      $display("[TB] FAIL vec%0d t=%0t: got x=%0d y=%0d fs=%b hs=%b vs=%b rgb=%h, exp x=%0d y=%0d fs=%b hs=%b vs=%b rgb=%h",
               vecCount, $time, xOut, yOut, frameStart, hsync, vsync, rgb,
               e.x, e.y, e.fs, e.hs, e.vs, e.rgb);
    end
  endtask

  int cyc = 0, lastFs = 0, hsRun = 0;
  bit fsSeen = 0, hsRunValid = 0;

  // Monitor: scoreboard pops plus fixed frame-period and hsync-width checks.
  always @(negedge clk) begin
    expT e;
    cyc++;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput(e);
    end
    if (frameStart === 1'b1) begin
      if (fsSeen) begin
        vecCount++;
        if (cyc - lastFs != 176) begin
          missCount++;
          $display("[TB] FAIL framePeriod: got %0d cycles, exp 176", cyc - lastFs);
        end
      end
      lastFs = cyc;
      fsSeen = 1;
    end
    if (hsync === 1'b0) begin
      hsRun++;
    end else begin
      if (hsRun > 0 && hsRunValid) begin
        vecCount++;
        if (hsRun != 3) begin
          missCount++;
          $display("[TB] FAIL hsyncWidth: got %0d cycles, exp 3", hsRun);
        end
      end
      hsRun = 0;
      hsRunValid = 1;
    end
    if (reset_n === 1'b0) begin
      fsSeen = 0;
      hsRun = 0;
      hsRunValid = 0;
    end
  end

  initial begin
    int guard;
    applyStimulus(5, 1'b0, 0, 1'b0, ST_INGAME);
    applyStimulus(2 * FRAME, 1'b1, 0, 1'b0, ST_INGAME);
    applyStimulus(FRAME, 1'b1, 1, 1'b0, ST_INGAME);
    applyStimulus(FRAME, 1'b1, 3, 1'b1, ST_TEST);
    applyStimulus(64 * FRAME, 1'b1, 2, 1'b1, ST_INGAME);
    applyStimulus(40 * FRAME, 1'b1, 2, 1'b1, ST_TEST);
    applyStimulus(FRAME, 1'b1, 3, 1'b0, ST_OVER);
    applyStimulus(FRAME, 1'b1, 3, 1'b1, ST_INGAME);
    guard = 0;
    while (!(mh == 5 && mv == 3) && guard < 2 * FRAME) begin
      applyStimulus(1, 1'b1, 0, 1'b0, ST_INGAME);
      guard++;
    end
    applyStimulus(3, 1'b0, 0, 1'b0, ST_INGAME);
    applyStimulus(2 * FRAME, 1'b1, 0, 1'b0, ST_INGAME);
    repeat (3) @(negedge clk);
    vecCount++;
    if (expQ.size() != 0) begin
      missCount++;
      $display("[TB] FAIL drain: got %0d queued, exp 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
